// File: rtl/fx2_stream_bridge.sv
// fx2_stream_bridge: FX2 slave-FIFO master. Streams FPGA words into the IN endpoint
// through an elastic TX buffer and assembles multi-word PC commands from the OUT endpoint.
// Optional feature macro: FX2_IDLE_FLUSH_EN (commit a short packet after IDLE_CYCLES
// cycles without a write strobe).
module fx2_stream_bridge #(
    parameter int          DATA_W      = 8,
    parameter int          CMD_WORDS   = 1,
    parameter int          TXBUF_DEPTH = 16,
    parameter int          IDLE_CYCLES = 1024,
    parameter logic [1:0]  RD_ADR      = 2'b00,
    parameter logic [1:0]  WR_ADR      = 2'b10
) (
    input  logic                          FX2_CLK,
    input  logic                          FX2_RST,
    inout  wire  [DATA_W-1:0]             FX2_FD,
    output logic                          FX2_SLRD,
    output logic                          FX2_SLWR,
    output logic                          FX2_SLOE,
    output logic [1:0]                    FX2_FIFOADR,
    output logic                          FX2_PKTEND,
    input  logic                          FX2_EP2_EF_N,
    input  logic                          FX2_EP6_FF_N,
    input  logic [DATA_W-1:0]             TX_DATA,
    input  logic                          TX_VALID,
    output logic                          TX_READY,
    output logic [CMD_WORDS*DATA_W-1:0]   CMD_DATA,
    output logic                          CMD_VALID
);

    localparam int AW = $clog2(TXBUF_DEPTH);
    localparam int CW = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;

    typedef enum logic [2:0] {S_WR, S_RTRN, S_RD, S_PTRN, S_PEND} state_t;

    state_t state, next_state;

    // TX buffer storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_W-1:0] mem [TXBUF_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              buf_empty, buf_full, push, pop;

    logic              wr_strobe, rd_strobe, oe_active, pkt_active;
    logic              idle_hit;

    logic [CMD_WORDS*DATA_W-1:0] cmd_buf, cmd_next;
    logic [CW-1:0]               word_cnt;
    logic                        last_word;

    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign TX_READY  = ~buf_full;
    assign push      = TX_VALID & ~buf_full;
    assign pop       = wr_strobe;

    assign FX2_SLWR   = ~wr_strobe;
    assign FX2_SLRD   = ~rd_strobe;
    assign FX2_SLOE   = ~oe_active;
    assign FX2_PKTEND = ~pkt_active;
    assign FX2_FD     = wr_strobe ? mem[rd_ptr[AW-1:0]] : 'z;

    // Buffer storage write; contents need no reset, only the pointers do
    always_ff @(posedge FX2_CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= TX_DATA;
        end
    end

    // Buffer pointers
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef FX2_IDLE_FLUSH_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    logic [IW-1:0] idle_cnt;
    logic [15:0]   uncommitted;

    assign idle_hit = (state == S_WR) && !wr_strobe && (uncommitted != '0) &&
                      (idle_cnt == IW'(IDLE_CYCLES - 1));

    // Idle counter and uncommitted-word count for the short-packet flush
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            idle_cnt    <= '0;
            uncommitted <= '0;
        end else begin
            if (state != S_WR || wr_strobe) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IW'(IDLE_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (state == S_PEND) begin
                uncommitted <= '0;
            end else if (wr_strobe && uncommitted != '1) begin
                uncommitted <= uncommitted + 1'b1;
            end
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) state <= S_WR;
        else         state <= next_state;
    end

    // FSM next state and strobes
    always_comb begin
        next_state = state;
        wr_strobe  = 1'b0;
        rd_strobe  = 1'b0;
        oe_active  = 1'b0;
        pkt_active = 1'b0;
        case (state)
            S_WR: begin
                wr_strobe = !buf_empty && FX2_EP6_FF_N;
                if (FX2_EP2_EF_N)  next_state = S_RTRN;
                else if (idle_hit) next_state = S_PEND;
            end
            S_RTRN: begin
                oe_active  = 1'b1;
                next_state = S_RD;
            end
            S_RD: begin
                oe_active = 1'b1;
                rd_strobe = FX2_EP2_EF_N;
                if (!FX2_EP2_EF_N) next_state = S_PTRN;
            end
            S_PTRN: begin
                next_state = S_PEND;
            end
            S_PEND: begin
                pkt_active = 1'b1;
                next_state = S_WR;
            end
            default: next_state = S_WR;
        endcase
    end

    // Endpoint address follows the state being entered
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            FX2_FIFOADR <= WR_ADR;
        end else if (next_state != state) begin
            FX2_FIFOADR <= (next_state == S_RTRN || next_state == S_RD) ? RD_ADR : WR_ADR;
        end
    end

    assign last_word = (word_cnt == CW'(CMD_WORDS - 1));

    // Command buffer with the incoming word dropped into its slot
    always_comb begin
        cmd_next = cmd_buf;
        for (int unsigned i = 0; i < CMD_WORDS; i++) begin
            if (i == 32'(word_cnt)) cmd_next[i*DATA_W +: DATA_W] = FX2_FD;
        end
    end

    // Command assembly; partial commands survive across read sessions
    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            cmd_buf   <= '0;
            word_cnt  <= '0;
            CMD_DATA  <= '0;
            CMD_VALID <= 1'b0;
        end else begin
            CMD_VALID <= 1'b0;
            if (rd_strobe) begin
                cmd_buf <= cmd_next;
                if (last_word) begin
                    CMD_DATA  <= cmd_next;
                    CMD_VALID <= 1'b1;
                    word_cnt  <= '0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fx2_stream_bridge.sv
// tb_fx2_stream_bridge: directed bench with a small FX2 endpoint model and bus monitor.
module tb_fx2_stream_bridge;

    localparam int DW    = 8;
    localparam int CWRDS = 2;
    localparam int DEPTH = 4;
    localparam int IDLE  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    wire  [DW-1:0]   fd;
    logic            slrd, slwr, sloe, pktend;
    logic [1:0]      fifoadr;
    logic            ep2_ef_n;
    logic            ep6_ff_n = 1'b1;
    logic [DW-1:0]   tx_data = '0;
    logic            tx_valid = 1'b0;
    logic            tx_ready;
    logic [CWRDS*DW-1:0] cmd_data;
    logic            cmd_valid;

    int checks = 0;
    int failures = 0;

    // OUT endpoint model: words the PC has queued, driven while SLOE is low
    logic [DW-1:0] ep2_mem [64];
    int            ep2_idx = 0;
    int            ep2_len = 0;
    assign ep2_ef_n = (ep2_idx != ep2_len);
    assign fd = sloe ? 8'hzz : ep2_mem[ep2_idx[5:0]];

    // Monitor records
    int            cyc = 0;
    int            wr_cyc[$];
    logic [DW-1:0] wr_dat[$];
    int            rd_cyc[$];
    int            pk_cyc[$];
    int            oe_cyc[$];
    int            cv_cyc[$];
    logic [15:0]   cv_dat[$];
    int            adr_err = 0;
    int            contention = 0;

    fx2_stream_bridge #(
        .DATA_W(DW), .CMD_WORDS(CWRDS), .TXBUF_DEPTH(DEPTH), .IDLE_CYCLES(IDLE),
        .RD_ADR(2'b00), .WR_ADR(2'b10)
    ) dut (
        .FX2_CLK(clk), .FX2_RST(rst), .FX2_FD(fd),
        .FX2_SLRD(slrd), .FX2_SLWR(slwr), .FX2_SLOE(sloe),
        .FX2_FIFOADR(fifoadr), .FX2_PKTEND(pktend),
        .FX2_EP2_EF_N(ep2_ef_n), .FX2_EP6_FF_N(ep6_ff_n),
        .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .CMD_DATA(cmd_data), .CMD_VALID(cmd_valid)
    );

    always #5 clk = ~clk;

    // Bus monitor and OUT endpoint read pointer
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!slwr) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(fd);
            if (fifoadr !== 2'b10) adr_err++;
        end
        if (!slrd) begin
            rd_cyc.push_back(cyc);
            if (fifoadr !== 2'b00) adr_err++;
            ep2_idx <= ep2_idx + 1;
        end
        if (!pktend)  pk_cyc.push_back(cyc);
        if (!sloe)    oe_cyc.push_back(cyc);
        if (cmd_valid) begin
            cv_cyc.push_back(cyc);
            cv_dat.push_back(cmd_data);
        end
    end

    // Contention watch: FPGA drives FD only on SLWR, FX2 drives while SLOE low
    always @(negedge clk) begin
        if (!sloe && !slwr) contention++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        tick(15);
        wr_cyc.delete(); wr_dat.delete(); rd_cyc.delete(); pk_cyc.delete();
        oe_cyc.delete(); cv_cyc.delete(); cv_dat.delete();
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic load_ep2(input logic [DW-1:0] a, input logic [DW-1:0] b, input int n);
        ep2_mem[ep2_len[5:0]] = a;
        if (n > 1) ep2_mem[6'(ep2_len + 1)] = b;
        ep2_len = ep2_len + n;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++; if (slrd !== 1'b1)      begin failures++; $display("FAIL %s slrd got %b want 1", tag, slrd); end
        checks++; if (slwr !== 1'b1)      begin failures++; $display("FAIL %s slwr got %b want 1", tag, slwr); end
        checks++; if (sloe !== 1'b1)      begin failures++; $display("FAIL %s sloe got %b want 1", tag, sloe); end
        checks++; if (pktend !== 1'b1)    begin failures++; $display("FAIL %s pktend got %b want 1", tag, pktend); end
        checks++; if (fifoadr !== 2'b10)  begin failures++; $display("FAIL %s fifoadr got %b want 10", tag, fifoadr); end
        checks++; if (tx_ready !== 1'b1)  begin failures++; $display("FAIL %s tx_ready got %b want 1", tag, tx_ready); end
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL %s cmd_valid got %b want 0", tag, cmd_valid); end
        checks++; if (cmd_data !== 16'h0) begin failures++; $display("FAIL %s cmd_data got %h want 0000", tag, cmd_data); end
    endtask

    task automatic test_reset();
        tick(2);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_write();
        clear_mon();
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        tick(5);
        checks++; if (wr_cyc.size() != 3) begin failures++; $display("FAIL wr_count got %0d want 3", wr_cyc.size()); end
        else begin
            checks++; if (wr_dat[0] !== 8'h11 || wr_dat[1] !== 8'h22 || wr_dat[2] !== 8'h33) begin
                failures++; $display("FAIL wr_data got %h %h %h want 11 22 33", wr_dat[0], wr_dat[1], wr_dat[2]); end
            checks++; if (wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1) begin
                failures++; $display("FAIL wr_consecutive got %0d %0d %0d", wr_cyc[0], wr_cyc[1], wr_cyc[2]); end
        end
        checks++; if (pk_cyc.size() != 0) begin failures++; $display("FAIL wr_no_pktend got %0d want 0", pk_cyc.size()); end
        checks++; if (adr_err != 0) begin failures++; $display("FAIL wr_fifoadr errors got %0d want 0", adr_err); end
    endtask

    task automatic test_read();
        clear_mon();
        load_ep2(8'hA5, 8'h5A, 2);
        tick(12);
        checks++; if (rd_cyc.size() != 2) begin failures++; $display("FAIL rd_count got %0d want 2", rd_cyc.size()); end
        checks++; if (oe_cyc.size() != 4) begin failures++; $display("FAIL rd_sloe_cycles got %0d want 4", oe_cyc.size()); end
        if (rd_cyc.size() == 2 && oe_cyc.size() == 4) begin
            checks++; if (rd_cyc[0] != oe_cyc[0] + 1) begin
                failures++; $display("FAIL rd_turnaround slrd at %0d want %0d", rd_cyc[0], oe_cyc[0] + 1); end
        end
        checks++; if (cv_cyc.size() != 1) begin failures++; $display("FAIL cmd_count got %0d want 1", cv_cyc.size()); end
        else begin
            checks++; if (cv_dat[0] !== 16'h5AA5) begin failures++; $display("FAIL cmd_data got %h want 5aa5", cv_dat[0]); end
            if (rd_cyc.size() == 2) begin
                checks++; if (cv_cyc[0] != rd_cyc[1] + 1) begin
                    failures++; $display("FAIL cmd_timing got %0d want %0d", cv_cyc[0], rd_cyc[1] + 1); end
            end
        end
        checks++; if (pk_cyc.size() != 1) begin failures++; $display("FAIL rd_pktend_count got %0d want 1", pk_cyc.size()); end
        else if (rd_cyc.size() == 2) begin
            checks++; if (pk_cyc[0] != rd_cyc[1] + 3) begin
                failures++; $display("FAIL rd_pktend_timing got %0d want %0d", pk_cyc[0], rd_cyc[1] + 3); end
        end
        checks++; if (fifoadr !== 2'b10 || sloe !== 1'b1) begin
            failures++; $display("FAIL rd_return adr %b sloe %b want 10 1", fifoadr, sloe); end
    endtask

    task automatic test_full();
        clear_mon();
        ep6_ff_n = 1'b0;
        push_word(8'hD0); push_word(8'hD1); push_word(8'hD2); push_word(8'hD3);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_ready got %b want 0", tx_ready); end
        tick(3);
        checks++; if (wr_cyc.size() != 0) begin failures++; $display("FAIL full_stall writes got %0d want 0", wr_cyc.size()); end
        ep6_ff_n = 1'b1;
        tick(1);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got %b want 1", tx_ready); end
        tick(6);
        checks++; if (wr_cyc.size() != 4) begin failures++; $display("FAIL full_drain got %0d want 4", wr_cyc.size()); end
        else begin
            checks++; if (wr_dat[0] !== 8'hD0 || wr_dat[1] !== 8'hD1 || wr_dat[2] !== 8'hD2 || wr_dat[3] !== 8'hD3) begin
                failures++; $display("FAIL full_order got %h %h %h %h want d0 d1 d2 d3", wr_dat[0], wr_dat[1], wr_dat[2], wr_dat[3]); end
        end
    endtask

    task automatic test_back_to_back();
        int exp_pk;
`ifdef FX2_IDLE_FLUSH_EN
        exp_pk = 2;
`else
        exp_pk = 1;
`endif
        clear_mon();
        ep6_ff_n = 1'b0;
        push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4);
        ep6_ff_n = 1'b1;
        tick(1);
        load_ep2(8'h3C, 8'hC3, 2);
        tick(25);
        checks++; if (wr_cyc.size() != 4) begin failures++; $display("FAIL pre_count got %0d want 4", wr_cyc.size()); end
        else begin
            checks++; if (wr_dat[0] !== 8'hA1 || wr_dat[1] !== 8'hA2 || wr_dat[2] !== 8'hA3 || wr_dat[3] !== 8'hA4) begin
                failures++; $display("FAIL pre_order got %h %h %h %h want a1 a2 a3 a4", wr_dat[0], wr_dat[1], wr_dat[2], wr_dat[3]); end
            checks++; if (pk_cyc.size() != exp_pk) begin failures++; $display("FAIL pre_pktend got %0d want %0d", pk_cyc.size(), exp_pk); end
            else begin
                checks++; if (!(pk_cyc[0] > wr_cyc[1] && pk_cyc[0] < wr_cyc[2])) begin
                    failures++; $display("FAIL pre_split pktend %0d writes %0d %0d", pk_cyc[0], wr_cyc[1], wr_cyc[2]); end
            end
        end
        checks++; if (cv_cyc.size() != 1 || cv_dat[0] !== 16'hC33C) begin
            failures++; $display("FAIL pre_cmd count %0d want 1 data c33c", cv_cyc.size()); end
        checks++; if (contention != 0) begin failures++; $display("FAIL pre_contention got %0d want 0", contention); end
    endtask

    task automatic test_idle_flush();
        clear_mon();
        push_word(8'h51); push_word(8'h52); push_word(8'h53); push_word(8'h54); push_word(8'h55);
        tick(30);
        checks++; if (wr_cyc.size() != 5) begin failures++; $display("FAIL idle_writes got %0d want 5", wr_cyc.size()); end
`ifdef FX2_IDLE_FLUSH_EN
        checks++; if (pk_cyc.size() != 1) begin failures++; $display("FAIL idle_pktend got %0d want 1", pk_cyc.size()); end
        else if (wr_cyc.size() == 5) begin
            checks++; if (pk_cyc[0] != wr_cyc[4] + IDLE + 1) begin
                failures++; $display("FAIL idle_timing got %0d want %0d", pk_cyc[0], wr_cyc[4] + IDLE + 1); end
        end
`else
        checks++; if (pk_cyc.size() != 0) begin failures++; $display("FAIL idle_pktend got %0d want 0", pk_cyc.size()); end
`endif
    endtask

    task automatic test_reset_mid_read();
        clear_mon();
        ep6_ff_n = 1'b0;
        push_word(8'hB1); push_word(8'hB2);
        load_ep2(8'h77, 8'h88, 2);
        tick(3);
        checks++; if (slrd !== 1'b0 || rd_cyc.size() != 1) begin
            failures++; $display("FAIL mid_read_setup slrd %b reads %0d want 0 1", slrd, rd_cyc.size()); end
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        ep2_len = ep2_idx;
        tick(2);
        rst = 1'b0;
        ep6_ff_n = 1'b1;
        tick(10);
        checks++; if (wr_cyc.size() != 0) begin failures++; $display("FAIL mid_buffer_discard writes got %0d want 0", wr_cyc.size()); end
        load_ep2(8'h12, 8'h34, 2);
        tick(15);
        checks++; if (cv_cyc.size() != 1) begin failures++; $display("FAIL mid_cmd_count got %0d want 1", cv_cyc.size()); end
        else begin
            checks++; if (cv_dat[0] !== 16'h3412) begin failures++; $display("FAIL mid_cmd_data got %h want 3412", cv_dat[0]); end
        end
        checks++; if (adr_err != 0 || contention != 0) begin
            failures++; $display("FAIL bus_rules adr_err %0d contention %0d want 0 0", adr_err, contention); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_back_to_back();
        test_idle_flush();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
